// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package : mips_defs
// Purpose : Shared constants for the MIPS pipeline memory-port arbiter:
//           FSM state encoding, the machine word width and the default
//           fetch-starvation limit.
// Revision: 1.0 - initial release
// ============================================================================
package mips_defs;

  // Machine word width (address and data buses).
  localparam int WORD_W = 32;

  // Consecutive data grants allowed while a fetch is waiting.
  localparam int STARVE_LIMIT_DEF = 4;

  // Arbiter FSM state encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

endpackage : mips_defs
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter
// Purpose : Shares one unified memory port between instruction fetch and the
//           MEM-stage load/store path. Serialises requests, drives the memory
//           handshake, returns data plus one-cycle completion pulses and
//           produces the fetch / MEM stall signals. Fetches cancelled by a
//           pipeline redirect still finish on the bus but are discarded.
//
// Ports   : clk, rst_n                       clock, async active-low reset
//           if_req/if_addr/if_cancel         fetch request side (in)
//           if_rdata/if_ready                fetch response (out)
//           dm_read/dm_write/dm_addr/dm_wdata data request side (in)
//           dm_rdata/dm_ready                data response (out)
//           stall_if/stall_mem               pipeline hold signals (out)
//           mem_req/mem_we/mem_addr/mem_wdata memory request (out)
//           mem_rdata/mem_ack                memory response (in)
//
// Revision: 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mips_defs::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF  // 1..15
) (
  input  logic              clk,
  input  logic              rst_n,
  // instruction fetch port
  input  logic              if_req,
  input  logic [WORD_W-1:0] if_addr,
  input  logic              if_cancel,
  output logic [WORD_W-1:0] if_rdata,
  output logic              if_ready,
  // data port
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [WORD_W-1:0] dm_addr,
  input  logic [WORD_W-1:0] dm_wdata,
  output logic [WORD_W-1:0] dm_rdata,
  output logic              dm_ready,
  // stalls
  output logic              stall_if,
  output logic              stall_mem,
  // memory port
  output logic              mem_req,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam logic [3:0] C_STARVE_LIM = 4'(STARVE_LIMIT);

  logic [1:0]        r_state;
  logic [3:0]        r_starve;
  logic              r_drop;
  logic              r_we;
  logic [WORD_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [WORD_W-1:0] r_if_rdata;
  logic [WORD_W-1:0] r_dm_rdata;
  logic              r_if_pend;
  logic              r_dm_pend;

  logic w_dm_any;
  logic w_busy;
  logic w_fetch_win;

  assign w_dm_any = dm_read | dm_write;
  assign w_busy   = (r_state == ST_FETCH) || (r_state == ST_DATA);

  // Data normally wins (older instruction); a starved fetch takes priority
  // once the counter has saturated. A cancelled fetch is never granted.
  assign w_fetch_win = if_req & ~if_cancel &
                       (~w_dm_any | (r_starve == C_STARVE_LIM));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_starve   <= 4'd0;
      r_drop     <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
      r_if_pend  <= 1'b0;
      r_dm_pend  <= 1'b0;
    end else begin
      // Completion flags live for exactly the RESP cycle.
      r_if_pend <= 1'b0;
      r_dm_pend <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!if_req) r_starve <= 4'd0;
          if (w_fetch_win) begin
            r_state  <= ST_FETCH;
            r_addr   <= if_addr;
            r_we     <= 1'b0;
            r_starve <= 4'd0;
          end else if (w_dm_any) begin
            r_state <= ST_DATA;
            r_addr  <= dm_addr;
            r_we    <= dm_write;     // read+write together acts as a store
            r_wdata <= dm_wdata;
            if (if_req && (r_starve != C_STARVE_LIM))
              r_starve <= r_starve + 4'd1;
          end
        end
        ST_FETCH: begin
          // The bus cycle cannot be aborted, so a redirect only marks the
          // result for disposal; the ack cycle itself also counts.
          if (if_cancel) r_drop <= 1'b1;
          if (mem_ack) begin
            r_state <= ST_RESP;
            if (!r_drop && !if_cancel) begin
              r_if_rdata <= mem_rdata;
              r_if_pend  <= 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (mem_ack) begin
            r_state   <= ST_RESP;
            r_dm_pend <= 1'b1;
            if (!r_we) r_dm_rdata <= mem_rdata;
          end
        end
        ST_RESP: begin
          // Returning to IDLE here keeps the ready pulse and the next grant
          // in different cycles.
          r_state <= ST_IDLE;
          r_drop  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // mem_req/mem_we decode from state so that reset drops them immediately.
  assign mem_req   = w_busy;
  assign mem_we    = w_busy & r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  // A redirect arriving in the response cycle still kills the pulse.
  assign if_ready  = r_if_pend & ~if_cancel;
  assign dm_ready  = r_dm_pend;

  assign stall_if  = if_req & ~if_ready & ~if_cancel;
  assign stall_mem = w_dm_any & ~dm_ready;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_port_arbiter
// Purpose : Self-checking bench for mem_port_arbiter. Directed stimulus pushes
//           expected bus transactions and read data into queues; a monitor
//           pops and compares on mem_ack, if_ready and dm_ready.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_cancel, dm_read, dm_write;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ready, dm_ready, stall_if, stall_mem, mem_req, mem_we, mem_ack;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory model ----------------
  int ack_delay;
  int wait_cnt;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    case (a)
      32'h0000_0040: return 32'h2408_0005;
      default:       return a ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= 0;
    else if (!mem_req || mem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  always_comb begin
    mem_ack   = mem_req && (wait_cnt == ack_delay);
    mem_rdata = mem_ack ? mem_val(mem_addr) : 32'hBAD0_BAD0;
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } bus_t;

  bus_t        bus_q[$];
  logic [31:0] if_q[$];
  logic [31:0] dm_q[$];
  logic [31:0] last_load;

  task automatic push_bus(input logic [31:0] a, input logic we, input logic [31:0] wd);
    bus_t e;
    e.addr = a; e.we = we; e.wdata = wd;
    bus_q.push_back(e);
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got pulse expected none (t=%0t)", name, $time);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_ack) begin
        if (bus_q.size() == 0) unexpected("bus_txn");
        else begin
          bus_t e;
          e = bus_q.pop_front();
          chk("bus_addr", mem_addr, e.addr);
          chk("bus_we", {31'd0, mem_we}, {31'd0, e.we});
          if (e.we) chk("bus_wdata", mem_wdata, e.wdata);
        end
      end
      if (if_ready) begin
        if (if_q.size() == 0) unexpected("if_ready");
        else chk("if_rdata", if_rdata, if_q.pop_front());
      end
      if (dm_ready) begin
        if (dm_q.size() == 0) unexpected("dm_ready");
        else chk("dm_rdata", dm_rdata, dm_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic wait_dm(input string name);
    bit got = 0;
    for (int i = 0; i < 20; i++) begin
      smp();
      if (dm_ready) begin
        got = 1;
        break;
      end
      adv();
    end
    chk(name, {31'd0, got}, 32'd1);
  endtask

  function automatic logic [31:0] daddr(input int i);
    return 32'h1000_0100 + 32'(4 * i);
  endfunction

  initial begin
    rst_n = 1'b0; if_req = 0; if_cancel = 0; dm_read = 0; dm_write = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; ack_delay = 0; last_load = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    smp();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    chk("rst_ready", {30'd0, if_ready, dm_ready}, 32'd0);
    adv();

    // lone fetch, zero-wait
    if_req = 1; if_addr = 32'h40;
    push_bus(32'h40, 1'b0, 32'h0); if_q.push_back(32'h2408_0005);
    smp(); chk("t1_c0_stall_if", {31'd0, stall_if}, 32'd1);
           chk("t1_c0_mem_req", {31'd0, mem_req}, 32'd0); adv();
    smp(); chk("t1_c1_mem_req", {31'd0, mem_req}, 32'd1);
           chk("t1_c1_stall_if", {31'd0, stall_if}, 32'd1); adv();
    smp(); chk("t1_c2_if_ready", {31'd0, if_ready}, 32'd1);
           chk("t1_c2_stall_if", {31'd0, stall_if}, 32'd0); adv();
    if_req = 0;
    smp(); chk("t1_c3_mem_req", {31'd0, mem_req}, 32'd0); adv();

    // fetch and load together: data first
    if_req = 1; if_addr = 32'h44; dm_read = 1; dm_addr = 32'h1000_0000;
    push_bus(32'h1000_0000, 1'b0, 32'h0); push_bus(32'h44, 1'b0, 32'h0);
    last_load = mem_val(32'h1000_0000); dm_q.push_back(last_load);
    if_q.push_back(mem_val(32'h44));
    smp(); chk("t2_c0_stall_mem", {31'd0, stall_mem}, 32'd1); adv();
    smp(); chk("t2_c1_mem_addr", mem_addr, 32'h1000_0000);
           chk("t2_c1_stall_if", {31'd0, stall_if}, 32'd1); adv();
    smp(); chk("t2_c2_dm_ready", {31'd0, dm_ready}, 32'd1);
           chk("t2_c2_stall_mem", {31'd0, stall_mem}, 32'd0);
           chk("t2_c2_stall_if", {31'd0, stall_if}, 32'd1); adv();
    dm_read = 0;
    smp(); chk("t2_c3_stall_if", {31'd0, stall_if}, 32'd1); adv();
    smp(); chk("t2_c4_mem_addr", mem_addr, 32'h44);
           chk("t2_c4_mem_req", {31'd0, mem_req}, 32'd1); adv();
    smp(); chk("t2_c5_if_ready", {31'd0, if_ready}, 32'd1); adv();
    if_req = 0; adv();

    // store with 3 wait states
    dm_write = 1; dm_addr = 32'h1000_0004; dm_wdata = 32'hDEAD_BEEF; ack_delay = 3;
    push_bus(32'h1000_0004, 1'b1, 32'hDEAD_BEEF); dm_q.push_back(last_load);
    smp(); chk("t3_c0_stall_mem", {31'd0, stall_mem}, 32'd1); adv();
    for (int k = 1; k <= 4; k++) begin
      smp();
      chk("t3_mem_req", {31'd0, mem_req}, 32'd1);
      chk("t3_mem_we", {31'd0, mem_we}, 32'd1);
      chk("t3_mem_addr", mem_addr, 32'h1000_0004);
      chk("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("t3_stall_mem", {31'd0, stall_mem}, 32'd1);
      adv();
    end
    smp(); chk("t3_c5_dm_ready", {31'd0, dm_ready}, 32'd1);
           chk("t3_c5_mem_req", {31'd0, mem_req}, 32'd0); adv();
    dm_write = 0; ack_delay = 0; adv();

    // read and write both high acts as a store
    dm_read = 1; dm_write = 1; dm_addr = 32'h1000_0008; dm_wdata = 32'h1234_5678;
    push_bus(32'h1000_0008, 1'b1, 32'h1234_5678); dm_q.push_back(last_load);
    wait_dm("t3b_dm_ready_seen");
    adv();
    dm_read = 0; dm_write = 0; adv();

    // starvation: 4 data grants, then the fetch, then data wins again
    begin
      int dcount = 0;
      int fcount = 0;
      bit done = 0;
      if_req = 1; if_addr = 32'h80; dm_read = 1; dm_addr = daddr(0);
      for (int i = 0; i < 4; i++) push_bus(daddr(i), 1'b0, 32'h0);
      push_bus(32'h80, 1'b0, 32'h0);
      push_bus(daddr(4), 1'b0, 32'h0);
      push_bus(32'h84, 1'b0, 32'h0);
      for (int i = 0; i < 5; i++) dm_q.push_back(mem_val(daddr(i)));
      last_load = mem_val(daddr(4));
      if_q.push_back(mem_val(32'h80)); if_q.push_back(mem_val(32'h84));
      for (int c = 0; c < 80 && !done; c++) begin
        bit rd, rf;
        smp(); rd = dm_ready; rf = if_ready;
        adv();
        if (rd) begin
          dcount++;
          if (dcount == 5) dm_read = 0; else dm_addr = daddr(dcount);
        end
        if (rf) begin
          fcount++;
          if (fcount == 1) if_addr = 32'h84;
          else begin if_req = 0; done = 1; end
        end
      end
      chk("t4_completed", {31'd0, done}, 32'd1);
    end

    // cancel during FETCH with 2 wait states
    if_req = 1; if_addr = 32'h100; ack_delay = 2;
    push_bus(32'h100, 1'b0, 32'h0);
    smp(); chk("t5_c0_mem_req", {31'd0, mem_req}, 32'd0); adv();
    if_cancel = 1; if_req = 0;
    smp(); chk("t5_c1_mem_req", {31'd0, mem_req}, 32'd1);
           chk("t5_c1_stall_if", {31'd0, stall_if}, 32'd0); adv();
    if_cancel = 0; if_req = 1; if_addr = 32'h200;
    smp(); chk("t5_c2_mem_addr", mem_addr, 32'h100); adv();
    smp(); chk("t5_c3_mem_req", {31'd0, mem_req}, 32'd1); adv();
    ack_delay = 0;
    smp(); chk("t5_c4_if_ready", {31'd0, if_ready}, 32'd0);
           chk("t5_c4_if_rdata", if_rdata, mem_val(32'h84)); adv();
    push_bus(32'h200, 1'b0, 32'h0); if_q.push_back(mem_val(32'h200));
    smp(); chk("t5_c5_stall_if", {31'd0, stall_if}, 32'd1); adv();
    smp(); chk("t5_c6_mem_addr", mem_addr, 32'h200); adv();
    smp(); chk("t5_c7_if_ready", {31'd0, if_ready}, 32'd1); adv();
    if_req = 0;

    // cancel and new request together in IDLE: no grant that cycle
    if_req = 1; if_addr = 32'h300; if_cancel = 1;
    smp(); chk("t6_c0_stall_if", {31'd0, stall_if}, 32'd0); adv();
    if_cancel = 0;
    push_bus(32'h300, 1'b0, 32'h0); if_q.push_back(mem_val(32'h300));
    smp(); chk("t6_c1_mem_req", {31'd0, mem_req}, 32'd0); adv();
    smp(); chk("t6_c2_mem_addr", mem_addr, 32'h300); adv();
    smp(); chk("t6_c3_if_ready", {31'd0, if_ready}, 32'd1); adv();
    if_req = 0;

    // reset during DATA
    dm_read = 1; dm_addr = 32'h1000_0010; ack_delay = 5;
    adv();
    smp(); chk("t7_c1_mem_req", {31'd0, mem_req}, 32'd1); adv();
    rst_n = 0; dm_read = 0;
    #1;
    chk("t7_rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("t7_rst_mem_addr", mem_addr, 32'd0);
    chk("t7_rst_mem_wdata", mem_wdata, 32'd0);
    chk("t7_rst_if_rdata", if_rdata, 32'd0);
    chk("t7_rst_dm_rdata", dm_rdata, 32'd0);
    chk("t7_rst_stall_mem", {31'd0, stall_mem}, 32'd0);
    last_load = '0;
    smp(); rst_n = 1; adv();
    dm_read = 1; dm_addr = 32'h1000_0010; ack_delay = 0;
    push_bus(32'h1000_0010, 1'b0, 32'h0);
    last_load = mem_val(32'h1000_0010); dm_q.push_back(last_load);
    smp(); adv();
    smp(); chk("t7_re_mem_req", {31'd0, mem_req}, 32'd1); adv();
    smp(); chk("t7_re_dm_ready", {31'd0, dm_ready}, 32'd1); adv();
    dm_read = 0;
    repeat (3) adv();

    chk("bus_q_left", 32'(bus_q.size()), 32'd0);
    chk("if_q_left", 32'(if_q.size()), 32'd0);
    chk("dm_q_left", 32'(dm_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire
